hpi_bus_arbiter: RTL and testbench

Hardware sequencer and two-port arbiter for the 16-bit HPI bus of the on-board USB host controller. It sits between the requesters that need the controller (port 0: Nios PIO bridge, port 1: hardware keyboard poller) and the HPI pins at the top level. It serialises their word transactions with round-robin fairness and generates correctly timed chip-select, read and write strobes with parameterised setup, strobe, hold and recovery intervals.

---
 rtl/hpi_pkg.sv | 19 +
 rtl/hpi_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_hpi_bus_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI bus sequencer/arbiter.
package hpi_pkg;

  localparam int unsigned HPI_DW = 16;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } hpi_state_e;

endpackage

// File: rtl/hpi_bus_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the 16-bit HPI bus.
module hpi_bus_arbiter
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_addr,
  input  logic [HPI_DW-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [HPI_DW-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_addr,
  input  logic [HPI_DW-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [HPI_DW-1:0] m1_rdata,
  output logic              busy,
  output logic              hpi_cs_n,
  output logic              hpi_rd_n,
  output logic              hpi_wr_n,
  output logic [1:0]        hpi_addr,
  output logic [HPI_DW-1:0] hpi_dout,
  output logic              hpi_dout_en,
  input  logic [HPI_DW-1:0] hpi_din
);

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  hpi_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [1:0]        addr_q, addr_d;
  logic [HPI_DW-1:0] wdata_q, wdata_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              den_q, den_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [HPI_DW-1:0] rdata0_q, rdata0_d;
  logic [HPI_DW-1:0] rdata1_q, rdata1_d;
  logic              capture;

  // State, interval counter and latched transaction registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= HPI_DATA;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: arbitration in IDLE, counter-paced phase sequencing elsewhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the port not granted last time wins.
          gnt_d   = (m0_req && m1_req) ? ~last_q : m1_req;
          last_d  = gnt_d;
          we_d    = gnt_d ? m1_we    : m0_we;
          addr_d  = gnt_d ? m1_addr  : m0_addr;
          wdata_d = gnt_d ? m1_wdata : m0_wdata;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values, decoded from the upcoming state so pins are registered.
  always_comb begin
    cs_n_d   = !(state_d inside {SETUP, STROBE, HOLD});
    rd_n_d   = !((state_d == STROBE) && !we_d);
    wr_n_d   = !((state_d == STROBE) && we_d);
    den_d    = we_d && !cs_n_d;
    ack0_d   = (state_q == HOLD) && (state_d == RECOVER) && !gnt_q;
    ack1_d   = (state_q == HOLD) && (state_d == RECOVER) && gnt_q;
    capture  = (state_q == STROBE) && (cnt_q == '0) && !we_q;
    rdata0_d = (capture && !gnt_q) ? hpi_din : rdata0_q;
    rdata1_d = (capture && gnt_q)  ? hpi_din : rdata1_q;
  end

  // Registered HPI controls, acks and read-data holding registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      den_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      den_q    <= den_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign hpi_cs_n    = cs_n_q;
  assign hpi_rd_n    = rd_n_q;
  assign hpi_wr_n    = wr_n_q;
  assign hpi_addr    = addr_q;
  assign hpi_dout    = wdata_q;
  assign hpi_dout_en = den_q;
  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Directed bench for hpi_bus_arbiter: default-parameter instance plus a swept one.
module tb_hpi_bus_arbiter;
  import hpi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [1:0]  m0_addr = 0, m1_addr = 0;
  logic [15:0] m0_wdata = 0, m1_wdata = 0, din = 0;
  logic        m0_ack, m1_ack, busy, cs_n, rd_n, wr_n, dout_en;
  logic [15:0] m0_rdata, m1_rdata, dout;
  logic [1:0]  addr;

  logic        b_req = 0, b_we = 0, b_zero = 0;
  logic [1:0]  b_addr = 0, b_zaddr = 0;
  logic [15:0] b_wdata = 0, b_zdata = 0;
  logic        b_ack0, b_ack1, b_busy, b_cs_n, b_rd_n, b_wr_n, b_den;
  logic [15:0] b_rdata0, b_rdata1, b_dout;
  logic [1:0]  b_haddr;

  hpi_bus_arbiter u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .busy(busy), .hpi_cs_n(cs_n), .hpi_rd_n(rd_n), .hpi_wr_n(wr_n),
    .hpi_addr(addr), .hpi_dout(dout), .hpi_dout_en(dout_en), .hpi_din(din)
  );

  hpi_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(1)) u_dut_sw (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata),
    .m0_ack(b_ack0), .m0_rdata(b_rdata0),
    .m1_req(b_zero), .m1_we(b_zero), .m1_addr(b_zaddr), .m1_wdata(b_zdata),
    .m1_ack(b_ack1), .m1_rdata(b_rdata1),
    .busy(b_busy), .hpi_cs_n(b_cs_n), .hpi_rd_n(b_rd_n), .hpi_wr_n(b_wr_n),
    .hpi_addr(b_haddr), .hpi_dout(b_dout), .hpi_dout_en(b_den), .hpi_din(din)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle trace (active-high versions of the strobes).
  logic        t_cs[64], t_wr[64], t_rd[64], t_den[64], t_busy[64], tb_wr[64];
  logic [1:0]  t_addr[64];
  logic [15:0] t_dout[64], t_r1[64];
  int q0[$], q1[$], qb[$];

  function automatic int n_set(input logic v[64], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int first_set(input logic v[64], input int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Caller raises requests just after an edge; cycle 0 is the cycle that follows.
  // holdN >= 0: drop that port's req holdN cycles after the cycle following its first ack.
  task automatic run(input int n, input int hold0, input int hold1);
    int f0 = -1, f1 = -1;
    q0.delete(); q1.delete(); qb.delete();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (hold0 >= 0 && f0 >= 0 && k == f0 + 1 + hold0) m0_req = 0;
        if (hold1 >= 0 && f1 >= 0 && k == f1 + 1 + hold1) m1_req = 0;
      end
      @(negedge clk);
      t_cs[k] = ~cs_n; t_wr[k] = ~wr_n; t_rd[k] = ~rd_n; t_den[k] = dout_en;
      t_busy[k] = busy; t_addr[k] = addr; t_dout[k] = dout; t_r1[k] = m1_rdata;
      tb_wr[k] = ~b_wr_n;
      if (m0_ack) begin q0.push_back(k); if (f0 < 0) f0 = k; end
      if (m1_ack) begin q1.push_back(k); if (f1 < 0) f1 = k; end
      if (b_ack0) qb.push_back(k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  int mism, starts, second_start;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_rd_wr", {rd_n, wr_n}, 2'b11);
    check("rst_den_busy_ack", {dout_en, busy, m0_ack, m1_ack}, 4'b0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Single write from port 0
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = HPI_ADDRESS; m0_wdata = 16'h0144;
    run(20, 0, -1);
    check("wr_cs_cycles", n_set(t_cs, 20), 6);
    check("wr_cs_first", first_set(t_cs, 20), 1);
    check("wr_strobe_cycles", n_set(t_wr, 20), 4);
    check("wr_strobe_first", first_set(t_wr, 20), 2);
    check("wr_rd_never", n_set(t_rd, 20), 0);
    mism = 0;
    for (int i = 0; i < 20; i++) if (t_den[i] != t_cs[i]) mism++;
    check("wr_den_tracks_cs", mism, 0);
    check("wr_ack_count", q0.size(), 1);
    check("wr_ack_cycle", (q0.size() > 0) ? q0[0] : -1, 7);
    check("wr_m1_ack_none", q1.size(), 0);
    check("wr_addr", t_addr[1], 2'd2);
    check("wr_dout", t_dout[1], 16'h0144);
    check("wr_busy_c0_c1_c9", {t_busy[0], t_busy[1], t_busy[9]}, 3'b010);

    // Single read from port 1
    @(posedge clk); #1;
    din = 16'hBEEF;
    m1_req = 1; m1_we = 0; m1_addr = HPI_DATA;
    run(20, -1, 0);
    check("rd_ack_cycle", (q1.size() > 0) ? q1[0] : -1, 7);
    check("rd_rdata_at_ack", t_r1[7], 16'hBEEF);
    check("rd_den_never", n_set(t_den, 20), 0);
    check("rd_wr_never", n_set(t_wr, 20), 0);
    check("rd_strobe_cycles", n_set(t_rd, 20), 4);
    check("rd_addr", t_addr[2], 2'd0);
    check("rd_m0_rdata_untouched", m0_rdata, 16'h0000);
    din = 16'h0000;

    // Contention from reset, both held
    do_reset();
    check("rst_clears_rdata", m1_rdata, 16'h0000);
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = HPI_MAILBOX; m0_wdata = 16'h1111;
    m1_req = 1; m1_we = 1; m1_addr = HPI_STATUS;  m1_wdata = 16'h2222;
    run(40, -1, -1);
    check("rr_m0_acks", q0.size(), 2);
    check("rr_m1_acks", q1.size(), 2);
    check("rr_first_m0", (q0.size() > 0) ? q0[0] : -1, 7);
    check("rr_second_m1", (q1.size() > 0) ? q1[0] : -1, 16);
    check("rr_third_m0", (q0.size() > 1) ? q0[1] : -1, 25);
    check("rr_fourth_m1", (q1.size() > 1) ? q1[1] : -1, 34);
    m0_req = 0; m1_req = 0;

    // Reset in the 2nd STROBE cycle
    do_reset();
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_addr = HPI_MAILBOX; m1_wdata = 16'h1234;
    repeat (3) @(posedge clk);
    #2;
    check("mid_pre_strobe", {cs_n, wr_n, dout_en}, 3'b001);
    rst_n = 0;
    #1;
    check("mid_async_ctrl", {cs_n, rd_n, wr_n}, 3'b111);
    check("mid_async_den_busy", {dout_en, busy}, 2'b00);
    m1_req = 0;
    mism = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1;
      if (m0_ack || m1_ack) mism++;
    end
    check("mid_no_ack", mism, 0);
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
    run(12, 0, -1);
    check("mid_tie_to_m0", (q0.size() > 0) ? q0[0] : -1, 7);
    check("mid_tie_m1_waits", q1.size(), 0);
    m1_req = 0;
    repeat (12) @(negedge clk);

    // Swept-parameter instance
    @(posedge clk); #1;
    b_req = 1; b_we = 1; b_addr = HPI_DATA; b_wdata = 16'hA5A5;
    run(20, -1, -1);
    check("sw_strobe_width", n_set(tb_wr, 8), 1);
    check("sw_ack_latency", (qb.size() > 0) ? qb[0] : -1, 7);
    check("sw_period", (qb.size() > 1) ? qb[1] - qb[0] : -1, 8);
    b_req = 0;
    repeat (12) @(negedge clk);

    // Late request drop: req held 3 cycles past ack
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = HPI_DATA; m0_wdata = 16'h00FF;
    run(30, 3, -1);
    starts = 0; second_start = -1;
    for (int i = 1; i < 30; i++)
      if (t_cs[i] && !t_cs[i-1]) begin
        starts++;
        if (starts == 2) second_start = i;
      end
    check("late_ack_count", q0.size(), 2);
    check("late_second_ack", (q0.size() > 1) ? q0[1] : -1, 16);
    check("late_txn_count", starts, 2);
    check("late_second_start", second_start, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
